bop_predictor: RTL and testbench

Direct-mapped branch target predictor in the fetch stage, directly upstream of the buffer of predictions (BOP). Each fetch address is looked up in a table of tagged entries, each holding a target and a 2-bit saturating counter. On a confident hit it registers a taken prediction for FE1 and pushes the predicted target into the BOP, where it waits for the MA stage. Resolved control-transfer outcomes from MA train the table.

---
 rtl/bop_predictor.sv | 97 +++++++++
 tb/tb_bop_predictor.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bop_predictor.sv
// Direct-mapped branch target predictor feeding the buffer of predictions (BOP).
// FE0 lookup registers an FE1 prediction; MA-stage resolutions train the table.
module bop_predictor #(
    parameter int ENTRIES   = 8,
    parameter int BOP_WIDTH = 30
) (
    input  logic                 s_clk_i,
    input  logic                 s_reset_i,
    input  logic                 s_flush_i,
    input  logic                 s_fetch_valid_i,
    input  logic [31:0]          s_fetch_addr_i,
    input  logic                 s_bop_full_i,
    input  logic                 s_upd_valid_i,
    input  logic [31:0]          s_upd_addr_i,
    input  logic                 s_upd_taken_i,
    input  logic [BOP_WIDTH-1:0] s_upd_target_i,
    output logic                 s_predict_o,
    output logic [31:0]          s_ptarget_o,
    output logic                 s_bop_push_o,
    output logic [BOP_WIDTH-1:0] s_bop_data_o
);
    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = 32 - IDX - 2;

    logic [ENTRIES-1:0]   r_valid;
    logic [TAGW-1:0]      r_tag    [ENTRIES];
    logic [BOP_WIDTH-1:0] r_target [ENTRIES];
    logic [1:0]           r_cnt    [ENTRIES];

    logic                 r_predict;
    logic [BOP_WIDTH-1:0] r_pdata;

    logic [IDX-1:0]  w_fidx;
    logic [TAGW-1:0] w_ftag;
    logic [IDX-1:0]  w_uidx;
    logic [TAGW-1:0] w_utag;
    logic            w_hit;
    logic            w_take;
    logic            w_uhit;

    assign w_fidx = s_fetch_addr_i[IDX+1:2];
    assign w_ftag = s_fetch_addr_i[31:IDX+2];
    assign w_uidx = s_upd_addr_i[IDX+1:2];
    assign w_utag = s_upd_addr_i[31:IDX+2];

    // Only weakly/strongly-taken entries (cnt[1]) produce a prediction.
    assign w_hit  = s_fetch_valid_i & r_valid[w_fidx] & (r_tag[w_fidx] == w_ftag)
                    & r_cnt[w_fidx][1];
    assign w_take = w_hit & ~s_bop_full_i & ~s_flush_i;
    assign w_uhit = r_valid[w_uidx] & (r_tag[w_uidx] == w_utag);

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic w_sel;
            assign w_sel = s_upd_valid_i & (w_uidx == IDX'(gi));

            always_ff @(posedge s_clk_i or posedge s_reset_i) begin
                if (s_reset_i) begin
                    r_valid[gi]  <= 1'b0;
                    r_tag[gi]    <= '0;
                    r_target[gi] <= '0;
                    r_cnt[gi]    <= 2'b00;
                end else if (w_sel) begin
                    if (w_uhit) begin
                        if (s_upd_taken_i) begin
                            r_target[gi] <= s_upd_target_i;
                            if (r_cnt[gi] != 2'b11) r_cnt[gi] <= r_cnt[gi] + 2'b01;
                        end else if (r_cnt[gi] != 2'b00) begin
                            r_cnt[gi] <= r_cnt[gi] - 2'b01;
                        end
                    end else if (s_upd_taken_i) begin
                        // Allocation evicts whatever occupied this slot.
                        r_valid[gi]  <= 1'b1;
                        r_tag[gi]    <= w_utag;
                        r_target[gi] <= s_upd_target_i;
                        r_cnt[gi]    <= 2'b10;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge s_clk_i or posedge s_reset_i) begin
        if (s_reset_i) begin
            r_predict <= 1'b0;
            r_pdata   <= '0;
        end else begin
            r_predict <= w_take;
            r_pdata   <= w_take ? r_target[w_fidx] : '0;
        end
    end

    assign s_predict_o  = r_predict;
    assign s_ptarget_o  = {r_pdata, 2'b00};
    assign s_bop_push_o = r_predict;
    assign s_bop_data_o = r_pdata;
endmodule

// File: tb/tb_bop_predictor.sv
// Bench for bop_predictor: directed vector table, reset corner, and random
// traffic checked against a table-level reference model.
module tb_bop_predictor;
    logic        clk = 1'b0;
    logic        rst, flush, fv, full, uv, ut;
    logic [31:0] fa, ua;
    logic [29:0] utg;
    logic        pred, push;
    logic [31:0] ptgt;
    logic [29:0] bdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bop_predictor #(.ENTRIES(8), .BOP_WIDTH(30)) dut (
        .s_clk_i(clk), .s_reset_i(rst), .s_flush_i(flush),
        .s_fetch_valid_i(fv), .s_fetch_addr_i(fa), .s_bop_full_i(full),
        .s_upd_valid_i(uv), .s_upd_addr_i(ua), .s_upd_taken_i(ut),
        .s_upd_target_i(utg), .s_predict_o(pred), .s_ptarget_o(ptgt),
        .s_bop_push_o(push), .s_bop_data_o(bdata)
    );

    typedef struct {
        logic        uv;
        logic [31:0] ua;
        logic        ut;
        logic [29:0] utg;
        logic        fv;
        logic [31:0] fa;
        logic        full;
        logic        flush;
        logic        ep;
        logic [31:0] et;
    } vec_t;

    vec_t vq[$];

    // Reference model: one record per table slot, indexed by address bits [4:2].
    bit          m_valid [8];
    logic [26:0] m_tag   [8];
    logic [29:0] m_tgt   [8];
    int          m_cnt   [8];

    function automatic vec_t mk(input logic uv_, input logic [31:0] ua_, input logic ut_,
                                input logic [29:0] utg_, input logic fv_, input logic [31:0] fa_,
                                input logic full_, input logic flush_, input logic ep_,
                                input logic [31:0] et_);
        vec_t v;
        v.uv = uv_; v.ua = ua_; v.ut = ut_; v.utg = utg_; v.fv = fv_; v.fa = fa_;
        v.full = full_; v.flush = flush_; v.ep = ep_; v.et = et_;
        return v;
    endfunction

    task automatic check(input string name, input logic ep, input logic [31:0] et);
        n_tests++;
        if (pred !== ep || push !== ep || ptgt !== et || bdata !== et[31:2]) begin
            n_fail++;
            $display("FAIL %s: predict=%0b push=%0b ptarget=%h data=%h, want predict=push=%0b ptarget=%h data=%h",
                     name, pred, push, ptgt, bdata, ep, et, et[31:2]);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        uv = v.uv; ua = v.ua; ut = v.ut; utg = v.utg;
        fv = v.fv; fa = v.fa; full = v.full; flush = v.flush;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        uv = 0; ua = 0; ut = 0; utg = 0; fv = 0; fa = 0; full = 0; flush = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 0;
        end
    endtask

    initial begin
        vec_t v;
        logic        e_p;
        logic [31:0] e_t;
        int          fi, ui;

        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        //          uv  ua          ut  utg     fv  fa          full flush ep  et
        vq.push_back(mk(0, 32'h000, 0, 30'h00, 1, 32'h100, 0, 0, 0, 32'h000)); // empty table
        vq.push_back(mk(1, 32'h100, 1, 30'h80, 0, 32'h000, 0, 0, 0, 32'h000)); // allocate cnt=2
        vq.push_back(mk(0, 32'h000, 0, 30'h00, 1, 32'h100, 0, 0, 1, 32'h200));
        vq.push_back(mk(0, 32'h000, 0, 30'h00, 1, 32'h100, 1, 0, 0, 32'h000)); // BOP full
        vq.push_back(mk(0, 32'h000, 0, 30'h00, 1, 32'h100, 0, 1, 0, 32'h000)); // flush
        vq.push_back(mk(0, 32'h000, 0, 30'h00, 0, 32'h100, 0, 0, 0, 32'h000)); // fetch invalid
        vq.push_back(mk(0, 32'h000, 0, 30'h00, 1, 32'h100, 0, 0, 1, 32'h200));
        vq.push_back(mk(1, 32'h100, 0, 30'h00, 1, 32'h100, 0, 0, 1, 32'h200)); // pre-update cnt=2
        vq.push_back(mk(0, 32'h000, 0, 30'h00, 1, 32'h100, 0, 0, 0, 32'h000)); // cnt=1
        vq.push_back(mk(1, 32'h100, 0, 30'h00, 0, 32'h000, 0, 0, 0, 32'h000)); // cnt=0
        vq.push_back(mk(0, 32'h000, 0, 30'h00, 1, 32'h100, 0, 0, 0, 32'h000));
        vq.push_back(mk(1, 32'h100, 0, 30'h00, 1, 32'h100, 0, 0, 0, 32'h000)); // saturate at 0
        vq.push_back(mk(1, 32'h100, 1, 30'h90, 1, 32'h100, 0, 0, 0, 32'h000)); // cnt=1
        vq.push_back(mk(1, 32'h100, 1, 30'h91, 1, 32'h100, 0, 0, 0, 32'h000)); // same-cycle 1->2
        vq.push_back(mk(0, 32'h000, 0, 30'h00, 1, 32'h100, 0, 0, 1, 32'h244));
        vq.push_back(mk(1, 32'h100, 1, 30'h91, 1, 32'h100, 0, 0, 1, 32'h244)); // cnt=3
        vq.push_back(mk(1, 32'h100, 0, 30'h00, 1, 32'h100, 0, 0, 1, 32'h244)); // cnt=2
        vq.push_back(mk(1, 32'h100, 0, 30'h00, 1, 32'h100, 0, 0, 1, 32'h244)); // cnt=1
        vq.push_back(mk(0, 32'h000, 0, 30'h00, 1, 32'h100, 0, 0, 0, 32'h000));
        vq.push_back(mk(1, 32'h120, 1, 30'h55, 1, 32'h100, 0, 0, 0, 32'h000)); // alias evicts 0x100
        vq.push_back(mk(0, 32'h000, 0, 30'h00, 1, 32'h100, 0, 0, 0, 32'h000));
        vq.push_back(mk(0, 32'h000, 0, 30'h00, 1, 32'h120, 0, 0, 1, 32'h154));
        vq.push_back(mk(1, 32'h140, 0, 30'h00, 1, 32'h120, 0, 0, 1, 32'h154)); // NT miss: no change
        vq.push_back(mk(0, 32'h000, 0, 30'h00, 1, 32'h120, 0, 0, 1, 32'h154));
        vq.push_back(mk(1, 32'h120, 0, 30'h00, 1, 32'h120, 0, 1, 0, 32'h000)); // flush, update kept
        vq.push_back(mk(0, 32'h000, 0, 30'h00, 1, 32'h120, 0, 0, 0, 32'h000));

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i]);
            check($sformatf("vec%0d", i), vq[i].ep, vq[i].et);
        end

        // Asynchronous reset while a prediction is being presented.
        apply(mk(1, 32'h100, 1, 30'h80, 0, 32'h000, 0, 0, 0, 32'h000));
        apply(mk(0, 32'h000, 0, 30'h00, 1, 32'h100, 0, 0, 1, 32'h200));
        check("pre_reset_predict", 1'b1, 32'h200);
        idle_inputs();
        #2 rst = 1'b1;
        #1 check("async_reset_drop", 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        apply(mk(0, 32'h000, 0, 30'h00, 1, 32'h100, 0, 0, 0, 32'h000));
        check("post_reset_0x100", 1'b0, 32'h0);
        apply(mk(0, 32'h000, 0, 30'h00, 1, 32'h120, 0, 0, 0, 32'h000));
        check("post_reset_0x120", 1'b0, 32'h0);

        // Random traffic over 4 tags x 8 slots against the reference model.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < 400; n++) begin
            v.uv    = ($urandom_range(0, 99) < 60);
            v.ua    = ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
            v.ut    = ($urandom_range(0, 99) < 65);
            v.utg   = 30'($urandom);
            v.fv    = ($urandom_range(0, 99) < 80);
            v.fa    = ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
            v.full  = ($urandom_range(0, 99) < 15);
            v.flush = ($urandom_range(0, 99) < 10);

            fi  = int'(v.fa[4:2]);
            e_p = v.fv && m_valid[fi] && (m_tag[fi] == v.fa[31:5]) && (m_cnt[fi] >= 2)
                  && !v.full && !v.flush;
            e_t = e_p ? {m_tgt[fi], 2'b00} : 32'h0;

            if (v.uv) begin
                ui = int'(v.ua[4:2]);
                if (m_valid[ui] && m_tag[ui] == v.ua[31:5]) begin
                    if (v.ut) begin
                        m_cnt[ui] = (m_cnt[ui] + 1 > 3) ? 3 : m_cnt[ui] + 1;
                        m_tgt[ui] = v.utg;
                    end else begin
                        m_cnt[ui] = (m_cnt[ui] - 1 < 0) ? 0 : m_cnt[ui] - 1;
                    end
                end else if (v.ut) begin
                    m_valid[ui] = 1;
                    m_tag[ui]   = v.ua[31:5];
                    m_tgt[ui]   = v.utg;
                    m_cnt[ui]   = 2;
                end
            end

            apply(v);
            check($sformatf("rand%0d", n), e_p, e_t);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
